// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding from EX and MEM, load-use bubble
// insertion, EX back-pressure, branch flush and a saturating stall counter.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic              id_rs1_en,
  input  logic              id_rs2_en,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [DATA_W-1:0] rf_value1,
  input  logic [DATA_W-1:0] rf_value2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_wb_en,
  input  logic [ADDR_W-1:0] id_wb_addr,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_fwd_en,
  input  logic [ADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0] mem_fwd_value,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_wb_en,
  output logic [ADDR_W-1:0] ex_wb_addr,
  output logic              ex_mem_read,
  output logic [15:0]       stall_count
);

  logic              ex_fwd_ok;
  logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic              luh;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  // A load in EX has no result yet, so only ALU writes forward from EX.
  assign ex_fwd_ok = ex_valid & ex_wb_en & ~ex_mem_read;
  assign ex_hit1   = ex_fwd_ok & (ex_wb_addr == id_rs1);
  assign ex_hit2   = ex_fwd_ok & (ex_wb_addr == id_rs2);
  assign mem_hit1  = mem_fwd_en & (mem_fwd_addr == id_rs1);
  assign mem_hit2  = mem_fwd_en & (mem_fwd_addr == id_rs2);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    opnd_a = rf_value1;
    if (id_rs1_en) begin
      if (id_rs1 == '0)   opnd_a = '0;
      else if (ex_hit1)   opnd_a = ex_result;
      else if (mem_hit1)  opnd_a = mem_fwd_value;
    end
  end

  always_comb begin
    opnd_b = rf_value2;
    if (id_use_imm) begin
      opnd_b = id_imm;
    end else if (id_rs2_en) begin
      if (id_rs2 == '0)   opnd_b = '0;
      else if (ex_hit2)   opnd_b = ex_result;
      else if (mem_hit2)  opnd_b = mem_fwd_value;
    end
  end

  assign luh = id_valid & ex_valid & ex_mem_read & ex_wb_en & (ex_wb_addr != '0) &
               ((id_rs1_en & (ex_wb_addr == id_rs1)) |
                (id_rs2_en & ~id_use_imm & (ex_wb_addr == id_rs2)));

  assign stall_id = ~flush & id_valid & (luh | ~ex_ready);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_wb_en    <= 1'b0;
      ex_wb_addr  <= '0;
      ex_mem_read <= 1'b0;
    end else if (!ex_ready) begin
      // EX is busy: the held instruction stays put.
    end else if (luh) begin
      ex_valid    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_mem_read <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_op       <= id_op;
      ex_a        <= opnd_a;
      ex_b        <= opnd_b;
      ex_imm      <= id_imm;
      ex_wb_en    <= id_valid & id_wb_en;
      ex_wb_addr  <= id_wb_addr;
      ex_mem_read <= id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  stall_count <= '0;
    else if (stall_id && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, load-use bubble,
// back-pressure, flush, register zero and stall counter saturation.
module tb_id_ex_stage;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_rs1_en, id_rs2_en, id_use_imm, id_wb_en, id_mem_read;
  logic [OP_W-1:0]   id_op;
  logic [ADDR_W-1:0] id_rs1, id_rs2, id_wb_addr, mem_fwd_addr;
  logic [DATA_W-1:0] rf_value1, rf_value2, id_imm, ex_result, mem_fwd_value;
  logic              mem_fwd_en, ex_ready, flush;
  logic              stall_id, ex_valid, ex_wb_en, ex_mem_read;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [ADDR_W-1:0] ex_wb_addr;
  logic [15:0]       stall_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_count = '0;

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .rf_value1(rf_value1), .rf_value2(rf_value2), .id_imm(id_imm), .id_use_imm(id_use_imm),
    .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr), .id_mem_read(id_mem_read),
    .ex_result(ex_result), .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_value(mem_fwd_value), .ex_ready(ex_ready), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_wb_en(ex_wb_en), .ex_wb_addr(ex_wb_addr),
    .ex_mem_read(ex_mem_read), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock edge on which the bench expects stall_id=1.
  task automatic tick_stall();
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    tick();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_op = '0; id_rs1_en = 0; id_rs2_en = 0; id_rs1 = '0; id_rs2 = '0;
    rf_value1 = '0; rf_value2 = '0; id_imm = '0; id_use_imm = 0; id_wb_en = 0;
    id_wb_addr = '0; id_mem_read = 0; ex_result = '0; mem_fwd_en = 0;
    mem_fwd_addr = '0; mem_fwd_value = '0; ex_ready = 1; flush = 0;
  endtask

  // Place a plain instruction into EX that writes register wa (load if ld=1).
  task automatic put_in_ex(input logic [ADDR_W-1:0] wa, input logic ld);
    idle_inputs();
    id_valid = 1; id_wb_en = 1; id_wb_addr = wa; id_mem_read = ld;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%h want=0", ex_valid); end
    checks++; if (ex_a !== 16'h0000) begin failures++; $display("FAIL reset_ex_a got=%h want=0000", ex_a); end
    checks++; if (stall_count !== 16'h0000) begin failures++; $display("FAIL reset_stall_count got=%h want=0000", stall_count); end
  endtask

  task automatic test_basic();
    idle_inputs();
    id_valid = 1; id_op = 5'd3; id_rs1_en = 1; id_rs1 = 3'd2; rf_value1 = 16'h1234;
    id_rs2_en = 1; id_rs2 = 3'd1; rf_value2 = 16'h0042; id_wb_en = 1; id_wb_addr = 3'd4;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL basic_stall got=%b want=0", stall_id); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL basic_ex_valid got=%b want=1", ex_valid); end
    checks++; if (ex_a !== 16'h1234) begin failures++; $display("FAIL basic_ex_a got=%h want=1234", ex_a); end
    checks++; if (ex_b !== 16'h0042) begin failures++; $display("FAIL basic_ex_b got=%h want=0042", ex_b); end
    checks++; if (ex_op !== 5'd3 || ex_wb_addr !== 3'd4 || ex_wb_en !== 1'b1)
      begin failures++; $display("FAIL basic_fields got=%h/%h/%b want=03/4/1", ex_op, ex_wb_addr, ex_wb_en); end
    checks++; if (stall_count !== 16'h0000) begin failures++; $display("FAIL basic_stall_count got=%h want=0000", stall_count); end
  endtask

  // Also the back-to-back case: dependent ALU op directly behind its producer.
  task automatic test_fwd_priority();
    put_in_ex(3'd3, 1'b0);
    idle_inputs();
    id_valid = 1; id_rs1_en = 1; id_rs1 = 3'd3; rf_value1 = 16'h2222; ex_result = 16'hBEEF;
    mem_fwd_en = 1; mem_fwd_addr = 3'd3; mem_fwd_value = 16'h1111;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b want=0", stall_id); end
    tick();
    checks++; if (ex_a !== 16'hBEEF) begin failures++; $display("FAIL fwd_ex_prio got=%h want=beef", ex_a); end
    // Empty EX with an invalid ID slot; its wb_en must not leak through.
    id_valid = 0; id_wb_en = 1; id_wb_addr = 3'd3;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0)
      begin failures++; $display("FAIL invalid_slot got=%b/%b want=0/0", ex_valid, ex_wb_en); end
    id_valid = 1; id_wb_en = 0;
    tick();
    checks++; if (ex_a !== 16'h1111) begin failures++; $display("FAIL fwd_mem got=%h want=1111", ex_a); end
  endtask

  task automatic test_load_use();
    put_in_ex(3'd5, 1'b1);
    idle_inputs();
    id_valid = 1; id_rs2_en = 1; id_rs2 = 3'd5; rf_value2 = 16'h0BAD; id_wb_en = 1; id_wb_addr = 3'd6;
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL luh_stall got=%b want=1", stall_id); end
    tick_stall();
    checks++; if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0 || ex_mem_read !== 1'b0)
      begin failures++; $display("FAIL luh_bubble got=%b/%b/%b want=0/0/0", ex_valid, ex_wb_en, ex_mem_read); end
    checks++; if (stall_count !== exp_count) begin failures++; $display("FAIL luh_count got=%h want=%h", stall_count, exp_count); end
    mem_fwd_en = 1; mem_fwd_addr = 3'd5; mem_fwd_value = 16'h00AA;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL luh_release got=%b want=0", stall_id); end
    tick();
    checks++; if (ex_b !== 16'h00AA || ex_valid !== 1'b1)
      begin failures++; $display("FAIL luh_fwd got=%h/%b want=00aa/1", ex_b, ex_valid); end
  endtask

  task automatic test_imm_no_stall();
    put_in_ex(3'd5, 1'b1);
    idle_inputs();
    id_valid = 1; id_rs2_en = 1; id_rs2 = 3'd5; id_use_imm = 1; id_imm = 16'h0007; rf_value2 = 16'h0BAD;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL imm_stall got=%b want=0", stall_id); end
    tick();
    checks++; if (ex_b !== 16'h0007 || ex_imm !== 16'h0007 || ex_valid !== 1'b1)
      begin failures++; $display("FAIL imm_ex_b got=%h/%h/%b want=0007/0007/1", ex_b, ex_imm, ex_valid); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    id_valid = 1; id_op = 5'd9; id_rs1_en = 1; id_rs1 = 3'd1; rf_value1 = 16'h4321;
    rf_value2 = 16'h0055; id_wb_en = 1; id_wb_addr = 3'd2;
    tick();
    ex_ready = 0; id_op = 5'd1; rf_value1 = 16'h9999; rf_value2 = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL bp_stall_%0d got=%b want=1", i, stall_id); end
      tick_stall();
    end
    checks++; if (ex_a !== 16'h4321 || ex_b !== 16'h0055 || ex_op !== 5'd9 || ex_valid !== 1'b1)
      begin failures++; $display("FAIL bp_hold got=%h/%h/%h/%b want=4321/0055/09/1", ex_a, ex_b, ex_op, ex_valid); end
    checks++; if (stall_count !== exp_count) begin failures++; $display("FAIL bp_count got=%h want=%h", stall_count, exp_count); end
  endtask

  task automatic test_flush();
    flush = 1;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b want=0", stall_id); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_a !== 16'h0000 || ex_wb_en !== 1'b0)
      begin failures++; $display("FAIL flush_clear got=%b/%h/%b want=0/0000/0", ex_valid, ex_a, ex_wb_en); end
    checks++; if (stall_count !== exp_count) begin failures++; $display("FAIL flush_count got=%h want=%h", stall_count, exp_count); end
  endtask

  task automatic test_zero_reg();
    put_in_ex(3'd0, 1'b0);
    idle_inputs();
    id_valid = 1; id_rs1_en = 1; id_rs1 = 3'd0; rf_value1 = 16'h7777; ex_result = 16'h5555;
    mem_fwd_en = 1; mem_fwd_addr = 3'd0; mem_fwd_value = 16'h3333;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b want=0", stall_id); end
    tick();
    checks++; if (ex_a !== 16'h0000) begin failures++; $display("FAIL zero_ex_a got=%h want=0000", ex_a); end
    put_in_ex(3'd0, 1'b1);
    idle_inputs();
    id_valid = 1; id_rs1_en = 1; id_rs1 = 3'd0;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL zero_load_stall got=%b want=0", stall_id); end
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    id_valid = 1; ex_ready = 0;
    for (int i = 0; i < 70000; i++) tick_stall();
    checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h want=ffff", stall_count); end
    tick_stall();
    checks++; if (stall_count !== exp_count) begin failures++; $display("FAIL sat_hold got=%h want=%h", stall_count, exp_count); end
  endtask

  task automatic test_reset_mid_stall();
    rst = 1;
    tick();
    rst = 0;
    exp_count = '0;
    checks++; if (stall_count !== 16'h0000 || ex_valid !== 1'b0)
      begin failures++; $display("FAIL rst_mid_stall got=%h/%b want=0000/0", stall_count, ex_valid); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd_priority();
    test_load_use();
    test_imm_no_stall();
    test_backpressure();
    test_flush();
    test_zero_reg();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly downstream of the register file. Each cycle it takes the decoded instruction and the two register-file read values, resolves operand forwarding from the EX and MEM stages, and latches the result for EX. It detects load-use hazards, inserts bubbles, honours EX back-pressure and branch flushes, and keeps a saturating count of stall cycles.

## Interface
- DATA_W, 16, register/operand width (`RegValue`)
- ADDR_W, 3, register address width (`RegAddr`); address 0 is the zero register
- OP_W, 5, ALU opcode width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID presents a decoded instruction
- id_op  in  OP_W  ALU opcode
- id_rs1_en, id_rs2_en  in  1  the instruction reads operand 1 / operand 2
- id_rs1, id_rs2  in  ADDR_W  read addresses (the same addresses drive the register file)
- rf_value1, rf_value2  in  DATA_W  register-file read data, which already includes the WB bypass
- id_imm  in  DATA_W  extended immediate
- id_use_imm  in  1  operand B comes from id_imm instead of rs2
- id_wb_en, id_wb_addr  in  1 / ADDR_W  destination register
- id_mem_read  in  1  the instruction is a load
- ex_result  in  DATA_W  combinational ALU result of the instruction now held in EX
- mem_fwd_en, mem_fwd_addr, mem_fwd_value  in  1 / ADDR_W / DATA_W  the MEM-stage instruction's pending write
- ex_ready  in  1  EX accepts a new instruction this cycle
- flush  in  1  a branch is taken; kill the instruction held for EX
- stall_id  out  1  combinational; IF/ID must hold its instruction
- ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_wb_en, ex_wb_addr, ex_mem_read  out  registered; the instruction handed to EX
- stall_count  out  16  saturating count of cycles with stall_id=1

## Operation
- Register 0 operands:
  - Operand address 0 always resolves to 0x0000 and is never forwarded.
  - A write to address 0 never counts as a forwarding source or a hazard source.
- Operand A source priority, when id_rs1_en=1:
  - First, the EX instruction: taken if ex_valid & ex_wb_en & !ex_mem_read & ex_wb_addr==id_rs1. The value is ex_result.
  - Second, MEM: taken if mem_fwd_en & mem_fwd_addr==id_rs1. The value is mem_fwd_value.
  - Otherwise rf_value1.
- Operand B:
  - If id_use_imm=1, operand B is id_imm.
  - Otherwise it resolves from rs2 / rf_value2 with the same priority rules as operand A.
- Disabled operands: when id_rsN_en=0, the operand is rf_valueN unforwarded. Its value is don't-care but deterministic.
- Load-use hazard (luh):
  - Condition: id_valid & ex_valid & ex_mem_read & ex_wb_en & ex_wb_addr!=0 & ex_wb_addr matches an enabled rs1 or rs2.
  - rs2 is excluded from this check when id_use_imm=1.
- stall_id = !flush & id_valid & (luh | !ex_ready). When flush=1, stall_id=0.
- Next-state update, evaluated in priority order:
  1. rst: ex_valid=0 and every ex_* output=0; stall_count=0.
  2. flush: ex_valid<=0 and the other ex_* outputs are cleared to 0. The current ID instruction is discarded; upstream kills it.
  3. !ex_ready: all ex_* outputs hold.
  4. luh: bubble, meaning ex_valid<=0 and ex_wb_en<=0 and ex_mem_read<=0. The ID instruction stays put because stall_id=1.
  5. Otherwise: latch id_valid, the resolved operands and the remaining fields.
  - When id_valid=0, ex_valid<=0 and ex_wb_en<=0.
- stall_count:
  - Increments on every cycle with stall_id=1.
  - Saturates at 0xFFFF and never wraps.
  - Cleared only by rst.

## Timing
- Latency ID→EX is exactly 1 cycle when no stall occurs.
- A load-use hazard costs exactly 1 bubble cycle. In the next cycle the load has moved to MEM, and its value is forwarded via mem_fwd_*.
- Forward selection and stall_id are purely combinational. All outputs except stall_id change only on rising clk.
- Back-to-back dependent ALU instructions need no stall, because EX forwarding covers them.
- Reset asserted mid-stall takes priority over all other conditions. stall_count reads 0 in the cycle after reset.
- ex_ready=0 and luh both true: hold takes priority, stall_id=1, and stall_count increments once per cycle.

## Test plan
- Reset, then one instruction with rs1=2 and rf_value1=0x1234, no hazard → the next cycle shows ex_valid=1 and ex_a=0x1234; stall_count=0.
- EX holds a write of r3 with ex_result=0xBEEF, and MEM holds a write of r3 with value 0x1111; ID reads rs1=r3 → ex_a=0xBEEF. With EX invalid instead → ex_a=0x1111.
- Load into r5 in EX, ID reads rs2=r5 with id_use_imm=0:
  - Cycle 1: stall_id=1, then ex_valid=0 (bubble), and stall_count=1.
  - Cycle 2: MEM forwards 0x00AA → ex_b=0x00AA and ex_valid=1.
- Same load into r5, but the ID instruction uses id_use_imm=1 with imm=0x0007 → no stall, and ex_b=0x0007.
- ex_ready=0 for 3 cycles with a valid instruction latched → the ex_* outputs are unchanged, stall_id=1, and stall_count advances by 3.
- flush=1 while ex_ready=0 → next cycle ex_valid=0 and stall_id=0. Separately, hold stall_id=1 for 70000 cycles → stall_count=0xFFFF.
- rs1=0 while EX writes r0 with value 0x5555 → ex_a=0x0000 and no stall.
